// File: rtl/cic_pkg.sv
// Shared helpers for the CIC interpolator: register-width sizing and
// elaboration-time configuration checks.
package cic_pkg;

    // Minimum internal width: in_bits + ceil(n * log2(r * m)).
    function automatic int cic_internal_width(input int in_bits, input int r,
                                              input int m, input int n);
        longint gain;
        int     bits;
        gain = 1;
        for (int k = 0; k < n; k++) begin
            gain = gain * longint'(r * m);
        end
        bits = 0;
        for (int b = 0; b < 63; b++) begin
            if ((longint'(1) << b) < gain) begin
                bits = b + 1;
            end
        end
        return in_bits + bits;
    endfunction

    function automatic bit cic_shift_fits(input int s, input int out_bits, input int w);
        return (s + out_bits) <= w;
    endfunction

endpackage

// File: rtl/cic_interpolator_upsampler.sv
// Zero-stuffing upsampler: holds one comb output for R output-rate phases,
// emitting it on phase 0 and zeros afterwards; owns the input handshake.
module upsampler #(
    parameter int Width  = 30,
    parameter int Factor = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] c_i,
    input  logic             in_valid_i,
    input  logic             out_valid_i,
    input  logic             out_ready_i,
    output logic             in_ready_o,
    output logic             accept_o,
    output logic             advance_o,
    output logic [Width-1:0] u_o
);
    localparam int PW = $clog2(Factor);
    localparam logic [PW-1:0] LastPhase = PW'(Factor - 1);

    logic [Width-1:0] h_q, h_d;
    logic             h_full_q, h_full_d;
    logic [PW-1:0]    p_q, p_d;
    logic             last_phase;

    assign last_phase = (p_q == LastPhase);
    assign advance_o  = h_full_q && (!out_valid_i || out_ready_i);
    // A new word may land in the same cycle the last phase drains: no bubble.
    assign in_ready_o = !h_full_q || (advance_o && last_phase);
    assign accept_o   = in_valid_i && in_ready_o;
    assign u_o        = (p_q == '0) ? h_q : '0;

    always_comb begin
        h_d      = h_q;
        h_full_d = h_full_q;
        p_d      = p_q;
        if (accept_o) begin
            h_d      = c_i;
            h_full_d = 1'b1;
            p_d      = '0;
        end else if (advance_o) begin
            if (last_phase) begin
                h_full_d = 1'b0;
                p_d      = '0;
            end else begin
                p_d = p_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= '0;
            h_full_q <= 1'b0;
            p_q      <= '0;
        end else begin
            h_q      <= h_d;
            h_full_q <= h_full_d;
            p_q      <= p_d;
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: input-rate combs, zero-stuffing upsampler and
// output-rate integrators with valid/ready flow control on both sides.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int InputLengthBits     = 12,
    parameter int InterpolationFactor = 64,
    parameter int DelayLength         = 1,
    parameter int FilterOrder         = 3,
    parameter int InternalLengthBits  = 30,
    parameter int OutputShift         = 12,
    parameter int OutputLengthBits    = 18
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [InputLengthBits-1:0]  in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [OutputLengthBits-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int W  = InternalLengthBits;
    localparam int N  = FilterOrder;
    localparam int M  = DelayLength;
    localparam int FW = (N > 1) ? N - 1 : 1;

    logic          accept, advance;
    logic [W-1:0]  x_ext, c_n, u;
    logic [W-1:0]  stage_in [N];
    logic [W-1:0]  dly_q [N][M];
    logic [W-1:0]  integ_q [N];
    logic [FW-1:0] fill_q;
    logic          fill_tap;
    logic          out_valid_q, out_valid_d;

    generate
        if (!cic_shift_fits(OutputShift, OutputLengthBits, W)) begin : g_bad_cfg
            $error("cic_interpolator: OutputShift + OutputLengthBits exceeds InternalLengthBits");
        end

        if (InputLengthBits < W) begin : g_sext
            assign x_ext = {{(W - InputLengthBits){in[InputLengthBits-1]}}, in};
        end else if (InputLengthBits == W) begin : g_same
            assign x_ext = in;
        end else begin : g_trunc
            logic unused_in_hi;
            assign unused_in_hi = ^in[InputLengthBits-1:W];
            assign x_ext = in[W-1:0];
        end

        // Output becomes valid once the integrator chain has been primed N-1 deep.
        if (N == 1) begin : g_fill_n1
            logic unused_fill;
            assign unused_fill = fill_q[0];
            assign fill_tap    = 1'b1;
        end else begin : g_fill_nx
            assign fill_tap = fill_q[FW-1];
        end
    endgenerate

    always_comb begin
        c_n = x_ext;
        for (int k = 0; k < N; k++) begin
            stage_in[k] = c_n;
            c_n         = c_n - dly_q[k][M-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < M; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                dly_q[k][0] <= stage_in[k];
                for (int j = 1; j < M; j++) begin
                    dly_q[k][j] <= dly_q[k][j-1];
                end
            end
        end
    end

    upsampler #(
        .Width  (W),
        .Factor (InterpolationFactor)
    ) u_upsampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .c_i         (c_n),
        .in_valid_i  (in_valid),
        .out_valid_i (out_valid_q),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .accept_o    (accept),
        .advance_o   (advance),
        .u_o         (u)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        if (advance) begin
            out_valid_d = fill_tap;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Integrators wrap freely; the combs cancel the overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
            end
            fill_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (advance) begin
                integ_q[0] <= integ_q[0] + u;
                for (int k = 1; k < N; k++) begin
                    integ_q[k] <= integ_q[k] + integ_q[k-1];
                end
                fill_q <= FW'({fill_q, 1'b1});
            end
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = integ_q[N-1][OutputShift +: OutputLengthBits];
    assign out_valid = out_valid_q;

endmodule
